// File: rtl/ht_dl_pkg.sv
// Shared types for the ioctl download router: FSM states, FIFO entry layout
// and error-bit positions.
package ht_dl_pkg;

  localparam int DL_ADDR_MAX_W = 32;
  localparam int ERR_LIMIT     = 0;
  localparam int ERR_PROTO     = 1;

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    DRAIN,
    DONE
  } dl_state_t;

  typedef struct packed {
    logic [DL_ADDR_MAX_W-1:0] addr;
    logic [7:0]               data;
  } dl_entry_t;

endpackage

// File: rtl/ioctl_dl_router_fifo.sv
// Small show-ahead FIFO of download entries; the head entry is visible on
// rd_entry whenever the FIFO is not empty.
module ioctl_fifo
  import ht_dl_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk_sys,
  input  logic                       reset,
  input  logic                       push,
  input  dl_entry_t                  wr_entry,
  input  logic                       pop,
  output dl_entry_t                  rd_entry,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  dl_entry_t         mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign rd_entry = mem[rd_ptr];

  always_ff @(posedge clk_sys) begin
    if (do_push) mem[wr_ptr] <= wr_entry;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/ioctl_dl_router.sv
// Routes hps_io ioctl download bytes to per-index regions of core memory,
// with FIFO buffering, back-pressure, boot reset hold and error reporting.
module ioctl_dl_router
  import ht_dl_pkg::*;
#(
  parameter int                          IN_AW      = 14,
  parameter int                          OUT_AW     = 25,
  parameter int                          N_IDX      = 4,
  parameter logic [N_IDX*OUT_AW-1:0]     IDX_BASE   = {{(N_IDX-1){OUT_AW'('h10000)}}, {OUT_AW{1'b0}}},
  parameter logic [N_IDX*(IN_AW+1)-1:0]  IDX_LIMIT  = {N_IDX{1'b1, {IN_AW{1'b0}}}},
  parameter logic [N_IDX-1:0]            RESET_MASK = N_IDX'(1),
  parameter int                          FIFO_DEPTH = 4
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              dl_active,
  input  logic              dl_wr,
  input  logic [IN_AW-1:0]  dl_addr,
  input  logic [7:0]        dl_data,
  input  logic [7:0]        dl_idx,
  output logic              dl_wait,
  output logic              mem_wr,
  output logic [OUT_AW-1:0] mem_addr,
  output logic [7:0]        mem_data,
  input  logic              mem_ack,
  output logic              hold_reset,
  output logic              done,
  output logic [1:0]        err,
  output logic [IN_AW:0]    byte_count
);

  localparam int IDX_W = (N_IDX > 1) ? $clog2(N_IDX) : 1;
  localparam int CW    = $clog2(FIFO_DEPTH) + 1;
  localparam int BW    = IN_AW + 1;

  dl_state_t         state;
  logic              act_q;
  logic [IDX_W-1:0]  idx_q;
  logic              idx_ok_q;
  logic              idx_ok_in;

  logic              fifo_full;
  logic              fifo_empty;
  logic [CW-1:0]     fifo_count;
  dl_entry_t         push_entry;
  dl_entry_t         head;

  logic [OUT_AW-1:0] base_sel;
  logic [BW-1:0]     limit_sel;
  logic              in_limit;
  logic              wr_req;
  logic              push;
  logic              pop;
  logic              unused_addr_hi;

  always_comb begin
    idx_ok_in       = ({24'd0, dl_idx} < 32'(N_IDX));
    base_sel        = IDX_BASE[idx_q*OUT_AW +: OUT_AW];
    limit_sel       = IDX_LIMIT[idx_q*BW +: BW];
    in_limit        = ({1'b0, dl_addr} < limit_sel);
    wr_req          = (state == ACTIVE) && dl_wr && idx_ok_q;
    push            = wr_req && in_limit && !fifo_full;
    pop             = !fifo_empty && (!mem_wr || mem_ack);
    push_entry.addr = DL_ADDR_MAX_W'(base_sel + OUT_AW'(dl_addr));
    push_entry.data = dl_data;
  end

  assign dl_wait        = (fifo_count >= CW'(FIFO_DEPTH - 1)) || (state == DRAIN);
  assign unused_addr_hi = ^head.addr[DL_ADDR_MAX_W-1:OUT_AW];

  ioctl_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_sys  (clk_sys),
    .reset    (reset),
    .push     (push),
    .wr_entry (push_entry),
    .pop      (pop),
    .rd_entry (head),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      act_q      <= 1'b0;
      idx_q      <= '0;
      idx_ok_q   <= 1'b0;
      err        <= '0;
      byte_count <= '0;
      hold_reset <= 1'b0;
      done       <= 1'b0;
    end else begin
      act_q <= dl_active;
      done  <= 1'b0;
      case (state)
        IDLE: begin
          if (dl_active && !act_q) begin
            state      <= ACTIVE;
            idx_q      <= dl_idx[IDX_W-1:0];
            idx_ok_q   <= idx_ok_in;
            err        <= {!idx_ok_in, 1'b0};
            byte_count <= '0;
            hold_reset <= idx_ok_in && RESET_MASK[dl_idx[IDX_W-1:0]];
          end
        end
        ACTIVE: begin
          if (wr_req) begin
            if (!in_limit)               err[ERR_LIMIT] <= 1'b1;
            else if (fifo_full)          err[ERR_PROTO] <= 1'b1;
            else if (byte_count != '1)   byte_count     <= byte_count + 1'b1;
          end
          if (!dl_active) state <= DRAIN;
        end
        DRAIN: begin
          if (fifo_empty && !mem_wr) begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        DONE: begin
          state      <= IDLE;
          hold_reset <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Output stage: a write is held until acked; an ack refills from the FIFO on the same edge.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      mem_wr   <= 1'b0;
      mem_addr <= '0;
      mem_data <= '0;
    end else if (pop) begin
      mem_wr   <= 1'b1;
      mem_addr <= head.addr[OUT_AW-1:0];
      mem_data <= head.data;
    end else if (mem_ack) begin
      mem_wr   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ioctl_dl_router.sv
// Directed bench for ioctl_dl_router: single-byte download table plus burst,
// stall, limit and reset-in-drain sequences.
module tb_ioctl_dl_router;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic        dl_active;
  logic        dl_wr;
  logic [13:0] dl_addr;
  logic [7:0]  dl_data;
  logic [7:0]  dl_idx;
  logic        dl_wait;
  logic        mem_wr;
  logic [24:0] mem_addr;
  logic [7:0]  mem_data;
  logic        mem_ack;
  logic        hold_reset;
  logic        done;
  logic [1:0]  err;
  logic [14:0] byte_count;

  int n_vec = 0;
  int n_bad = 0;
  int done_cnt = 0;
  logic [24:0] cap_addr [$];
  logic [7:0]  cap_data [$];

  ioctl_dl_router #(
    .IN_AW      (14),
    .OUT_AW     (25),
    .N_IDX      (4),
    .IDX_BASE   ({25'h0010000, 25'h0010000, 25'h0010000, 25'h0000000}),
    .IDX_LIMIT  ({15'h4000, 15'd8, 15'h4000, 15'h4000}),
    .RESET_MASK (4'b0001),
    .FIFO_DEPTH (4)
  ) dut (
    .clk_sys    (clk_sys),
    .reset      (reset),
    .dl_active  (dl_active),
    .dl_wr      (dl_wr),
    .dl_addr    (dl_addr),
    .dl_data    (dl_data),
    .dl_idx     (dl_idx),
    .dl_wait    (dl_wait),
    .mem_wr     (mem_wr),
    .mem_addr   (mem_addr),
    .mem_data   (mem_data),
    .mem_ack    (mem_ack),
    .hold_reset (hold_reset),
    .done       (done),
    .err        (err),
    .byte_count (byte_count)
  );

  always #5 clk_sys = ~clk_sys;

  // Completed memory writes and done pulses, sampled mid-cycle.
  always @(negedge clk_sys) begin
    if (!reset && mem_wr && mem_ack) begin
      cap_addr.push_back(mem_addr);
      cap_data.push_back(mem_data);
    end
    if (done) done_cnt++;
  end

  typedef struct {
    logic [7:0]  idx;
    logic [13:0] addr;
    logic [7:0]  data;
    bit          exp_wr;
    logic [24:0] exp_addr;
    logic [1:0]  exp_err;
    bit          exp_hold;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic clear_caps();
    cap_addr.delete();
    cap_data.delete();
  endtask

  task automatic start_dl(input logic [7:0] idx);
    dl_idx    = idx;
    dl_active = 1'b1;
    tick();
  endtask

  task automatic write_byte(input logic [13:0] a, input logic [7:0] d);
    int guard;
    guard = 0;
    while (dl_wait && guard < 100) begin
      tick();
      guard++;
    end
    if (guard >= 100) begin
      n_vec++;
      n_bad++;
      $display("FAIL wait_timeout: dl_wait stuck high at addr %0h", a);
    end
    dl_wr   = 1'b1;
    dl_addr = a;
    dl_data = d;
    tick();
    dl_wr   = 1'b0;
  endtask

  task automatic end_dl(output logic [1:0] e, output logic h, output logic [14:0] bc);
    bit seen;
    seen      = 1'b0;
    e         = '0;
    h         = 1'b0;
    bc        = '0;
    dl_active = 1'b0;
    for (int k = 0; k < 200 && !seen; k++) begin
      @(negedge clk_sys);
      if (done) begin
        seen = 1'b1;
        e    = err;
        h    = hold_reset;
        bc   = byte_count;
      end
    end
    if (!seen) begin
      n_vec++;
      n_bad++;
      $display("FAIL done_timeout: no done pulse within 200 cycles");
    end
    tick();
    check("done_single", done, 0);
    check("hold_idle", hold_reset, 0);
  endtask

  initial begin
    logic [1:0]  e;
    logic        h;
    logic [14:0] bc;
    int          d0;

    reset     = 1'b1;
    dl_active = 1'b0;
    dl_wr     = 1'b0;
    dl_addr   = '0;
    dl_data   = '0;
    dl_idx    = '0;
    mem_ack   = 1'b1;

    vecs[0] = '{8'd1, 14'h0003, 8'hA5, 1'b1, 25'h0010003, 2'b00, 1'b0};
    vecs[1] = '{8'd0, 14'h3FFF, 8'h5A, 1'b1, 25'h0003FFF, 2'b00, 1'b1};
    vecs[2] = '{8'd2, 14'h0007, 8'h11, 1'b1, 25'h0010007, 2'b00, 1'b0};
    vecs[3] = '{8'd2, 14'h0008, 8'h22, 1'b0, 25'h0000000, 2'b01, 1'b0};
    vecs[4] = '{8'd3, 14'h1234, 8'h33, 1'b1, 25'h0011234, 2'b00, 1'b0};
    vecs[5] = '{8'd7, 14'h0000, 8'h44, 1'b0, 25'h0000000, 2'b10, 1'b0};
    vecs[6] = '{8'd4, 14'h0001, 8'h55, 1'b0, 25'h0000000, 2'b10, 1'b0};
    vecs[7] = '{8'd0, 14'h0000, 8'hFF, 1'b1, 25'h0000000, 2'b00, 1'b1};

    tick();
    tick();
    check("rst_mem_wr", mem_wr, 0);
    check("rst_dl_wait", dl_wait, 0);
    check("rst_hold", hold_reset, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_bc", byte_count, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_data", mem_data, 0);
    reset = 1'b0;
    tick();

    // Single-byte downloads, one per table row.
    for (int i = 0; i < 8; i++) begin
      clear_caps();
      d0 = done_cnt;
      start_dl(vecs[i].idx);
      check($sformatf("v%0d_hold_active", i), hold_reset, vecs[i].exp_hold);
      write_byte(vecs[i].addr, vecs[i].data);
      end_dl(e, h, bc);
      check($sformatf("v%0d_err", i), e, vecs[i].exp_err);
      check($sformatf("v%0d_hold_done", i), h, vecs[i].exp_hold);
      check($sformatf("v%0d_bc", i), bc, vecs[i].exp_wr ? 1 : 0);
      check($sformatf("v%0d_nwr", i), cap_addr.size(), vecs[i].exp_wr ? 1 : 0);
      if (vecs[i].exp_wr && cap_addr.size() > 0) begin
        check($sformatf("v%0d_addr", i), cap_addr[0], vecs[i].exp_addr);
        check($sformatf("v%0d_data", i), cap_data[0], vecs[i].data);
      end
      check($sformatf("v%0d_done_cnt", i), done_cnt - d0, 1);
      tick();
    end

    // 16-byte burst on the boot index with mem_ack tied high.
    clear_caps();
    d0 = done_cnt;
    start_dl(8'd0);
    for (int k = 0; k < 16; k++) begin
      write_byte(14'(k), 8'(8'h40 + k));
      check($sformatf("burst_hold_%0d", k), hold_reset, 1);
    end
    end_dl(e, h, bc);
    check("burst_nwr", cap_addr.size(), 16);
    for (int k = 0; k < 16 && k < cap_addr.size(); k++) begin
      check($sformatf("burst_addr_%0d", k), cap_addr[k], k);
      check($sformatf("burst_data_%0d", k), cap_data[k], 8'h40 + k);
    end
    check("burst_bc", bc, 16);
    check("burst_err", e, 0);
    check("burst_hold_done", h, 1);
    check("burst_done_cnt", done_cnt - d0, 1);
    tick();

    // mem_ack low for 20 cycles while the FIFO fills.
    clear_caps();
    mem_ack = 1'b0;
    start_dl(8'd0);
    for (int k = 0; k < 3; k++) write_byte(14'(k), 8'(8'h80 + k));
    check("stall_wait_occ2", dl_wait, 0);
    write_byte(14'd3, 8'h83);
    check("stall_wait_occ3", dl_wait, 1);
    check("stall_mem_wr", mem_wr, 1);
    for (int k = 0; k < 15; k++) tick();
    check("stall_addr_stable", mem_addr, 0);
    check("stall_data_stable", mem_data, 8'h80);
    check("stall_no_writes", cap_addr.size(), 0);
    mem_ack = 1'b1;
    for (int k = 4; k < 8; k++) write_byte(14'(k), 8'(8'h80 + k));
    end_dl(e, h, bc);
    check("stall_nwr", cap_addr.size(), 8);
    for (int k = 0; k < 8 && k < cap_addr.size(); k++) begin
      check($sformatf("stall_addr_%0d", k), cap_addr[k], k);
      check($sformatf("stall_data_%0d", k), cap_data[k], 8'h80 + k);
    end
    check("stall_bc", bc, 8);
    check("stall_err", e, 0);
    tick();

    // Index 2 is limited to 8 bytes; ten are offered.
    clear_caps();
    start_dl(8'd2);
    for (int k = 0; k < 10; k++) write_byte(14'(k), 8'(k));
    end_dl(e, h, bc);
    check("limit_nwr", cap_addr.size(), 8);
    if (cap_addr.size() == 8) check("limit_last_addr", cap_addr[7], 25'h0010007);
    check("limit_err", e, 2'b01);
    check("limit_bc", bc, 8);
    tick();

    // Reset while draining with a held write and two queued bytes.
    clear_caps();
    mem_ack = 1'b0;
    start_dl(8'd0);
    for (int k = 0; k < 3; k++) write_byte(14'(k), 8'(8'h90 + k));
    dl_active = 1'b0;
    tick();
    check("drain_wait", dl_wait, 1);
    check("drain_hold", hold_reset, 1);
    reset = 1'b1;
    #2;
    check("rstd_mem_wr", mem_wr, 0);
    check("rstd_hold", hold_reset, 0);
    check("rstd_wait", dl_wait, 0);
    check("rstd_err", err, 0);
    check("rstd_bc", byte_count, 0);
    tick();
    reset   = 1'b0;
    mem_ack = 1'b1;
    tick();
    clear_caps();
    start_dl(8'd1);
    write_byte(14'd5, 8'hC1);
    write_byte(14'd6, 8'hC2);
    end_dl(e, h, bc);
    check("post_nwr", cap_addr.size(), 2);
    if (cap_addr.size() == 2) begin
      check("post_addr0", cap_addr[0], 25'h0010005);
      check("post_data1", cap_data[1], 8'hC2);
    end
    check("post_err", e, 0);
    check("post_bc", bc, 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
